serial_adder: RTL and testbench

- Bit-serial ripple adder built around one full-adder cell. Each full adder is composed of two XOR gates plus AND/OR carry logic.
- Sits directly downstream of the XOR gate in the gate-level datapath. It consumes XOR sum bits one per clock and keeps the carry in a flip-flop.
- Adds two WIDTH-bit operands LSB-first over WIDTH cycles using a start/busy/done handshake.
- Serves as the sequential arithmetic stage ahead of the ALU.

---
 rtl/mhrd_pkg.sv | 12 +
 rtl/full_adder.sv | 18 +
 rtl/serial_adder.sv | 107 ++++++++++
 tb/tb_serial_adder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mhrd_pkg.sv
// Shared types for the gate-level datapath: serial adder state encoding.
package mhrd_pkg;

    localparam int unsigned SADD_STATE_W = 2;

    typedef enum logic [SADD_STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sadd_state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder: two XOR stages for the sum, AND/OR carry logic.
module full_adder (
    input  logic in1,
    input  logic in2,
    input  logic cin,
    output logic out,
    output logic cout
);

    logic p;

    // Propagate term from the first XOR, sum from the second
    assign p    = in1 ^ in2;
    assign out  = p ^ cin;
    // Carry: generate or propagated carry-in
    assign cout = (in1 & in2) | (cin & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
// through a single full_adder cell with the carry held in a flop.
// Optional subtract mode is enabled with the macro SERIAL_ADDER_SUB_EN.
module serial_adder
    import mhrd_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    sadd_state_t      state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             s_bit, c_nxt;

    // The single adder cell shared by every bit position
    full_adder u_fa (
        .in1  (a_sr[0]),
        .in2  (b_sr[0]),
        .cin  (carry),
        .out  (s_bit),
        .cout (c_nxt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: start only honoured in IDLE; DONE lasts exactly one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (cnt == CNT_W'(WIDTH - 1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, bit-serial shift, result publication
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            out    <= '0;
            cout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= in1;
                        cnt  <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        // Two's-complement subtract: invert B, force carry-in to 1
                        b_sr  <= sub ? ~in2 : in2;
                        carry <= sub ? 1'b1 : cin;
`else
                        b_sr  <= in2;
                        carry <= cin;
`endif
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {s_bit, res_sr[WIDTH-1:1]};
                    carry  <= c_nxt;
                    cnt    <= cnt + CNT_W'(1);
                end
                DONE: begin
                    out  <= res_sr;
                    cout <= carry;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH = 16); covers the sub port when
// SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         cin = 1'b0;
    logic         sub_tb = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] out;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_tb),
`endif
        .busy  (busy),
        .done  (done),
        .out   (out),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] eout;
        logic         ecout;
        int           edge_n;
        string        name;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pop an expectation on every done pulse; any done with nothing pending is wrong
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() == 0) begin
            if (rst_n) chk("spurious_done", 32'(done), 32'd0);
        end else if (done === 1'b1) begin
            e = q.pop_front();
            chk({e.name, "_out"}, 32'(out), 32'(e.eout));
            chk({e.name, "_cout"}, 32'(cout), 32'(e.ecout));
            chk({e.name, "_latency"}, 32'(cyc), 32'(e.edge_n));
        end
    end

    // Issue one operation; acc returns the index of the accepting edge
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, input logic [W-1:0] eo, input logic ec,
                         input bit track, input string name, output int acc);
        exp_t e;
        @(negedge clk);
        in1 = a; in2 = b; cin = c; sub_tb = s; start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        if (track) begin
            e.eout = eo; e.ecout = ec; e.edge_n = acc + W + 1; e.name = name;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_out"},  32'(out),  32'd0);
        chk({name, "_cout"}, 32'(cout), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc1;

        // Reset held two cycles, then idle with start low
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_idle("reset");
        end

        // Basic add; in1 disturbed mid-run must not matter
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b1, "basic", acc);
        repeat (3) @(negedge clk);
        chk("busy_in_run", 32'(busy), 32'd1);
        in1 = 16'hFFFF;
        wait_drain();

        // Full carry chain
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "ovf_cin0", acc);
        wait_drain();
        issue(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, "ovf_cin1", acc);
        wait_drain();

        // start held high across two operations: results 18 cycles apart
        @(negedge clk);
        in1 = 16'd3; in2 = 16'd4; cin = 1'b0; sub_tb = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        acc1 = cyc;
        q.push_back('{16'd7, 1'b0, acc1 + W + 1, "b2b_first"});
        q.push_back('{16'd30, 1'b0, acc1 + (W + 2) + W + 1, "b2b_second"});
        @(negedge clk);
        in1 = 16'd10; in2 = 16'd20;
        while (cyc < acc1 + W + 2) @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Extra start mid-run is ignored: exactly one done, original result
        issue(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b1, "ignore_start", acc);
        repeat (4) @(negedge clk);
        in1 = 16'hFFFF; in2 = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (25) @(negedge clk);
        chk("ignore_start_held_out", 32'(out), 32'h0300);

        // Reset during the 8th RUN cycle aborts without a done pulse
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, "abort", acc);
        while (cyc < acc + 7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle("abort");
        repeat (25) @(negedge clk);
        chk_idle("abort_later");
        issue(16'd5, 16'd6, 1'b0, 1'b0, 16'd11, 1'b0, 1'b1, "after_abort", acc);
        wait_drain();

`ifdef SERIAL_ADDER_SUB_EN
        // Subtract: cin ignored, cout=1 means no borrow
        issue(16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b1, "sub_noborrow", acc);
        wait_drain();
        issue(16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1, "sub_borrow", acc);
        wait_drain();
        issue(16'h0010, 16'h0001, 1'b0, 1'b0, 16'h0011, 1'b0, 1'b1, "sub0_add", acc);
        wait_drain();
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
